// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - request/result handshake bundle between decode, sequencer and result bus
interface alu_op_sequencer_if #(
    parameter int W = 20
);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         zero;
    logic         carry;
    logic         err;

    modport master (
        output in_valid, op, a, b, c_in, out_ready,
        input  in_ready, out_valid, res, zero, carry, err
    );

    modport slave (
        input  in_valid, op, a, b, c_in, out_ready,
        output in_ready, out_valid, res, zero, carry, err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - ALU op sequencer: single-cycle ops plus iterated rotate/multiply
// Optional completed-op counter port perf_ops when ALU_SEQ_PERF_EN is defined.
module alu_op_sequencer #(
    parameter int W         = 20,
    parameter int MUL_ITERS = 20
) (
    input  logic clk,
    input  logic rst_n,
`ifdef ALU_SEQ_PERF_EN
    output logic [15:0] perf_ops,
`endif
    alu_op_sequencer_if.slave bus
);
    localparam int CW = $clog2(MUL_ITERS + 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_SHL  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_ROTL = 4'd6;
    localparam logic [3:0] OP_ROTR = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_ADDC = 4'd9;

    typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_DONE} state_t;
    typedef enum logic [1:0] {IT_ROTL, IT_ROTR, IT_MUL} iter_t;

    state_t       state_q, state_d;
    iter_t        iter_q, iter_d;
    logic [W-1:0] res_q, res_d;
    logic [W-1:0] hi_q, hi_d;
    logic [W-1:0] opa_q, opa_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         zero_q, zero_d;
    logic         carry_q, carry_d;
    logic         err_q, err_d;

    logic [W:0]   add_s;
    logic [W:0]   mstep;
    logic [4:0]   rot_amt;
    logic [4:0]   rot_k;

    // Amounts 20..31 wrap once; 31 - 20 already lands below W.
    assign rot_amt = bus.b[4:0];
    assign rot_k   = (rot_amt >= 5'(W)) ? rot_amt - 5'(W) : rot_amt;

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        res_d   = res_q;
        hi_d    = hi_q;
        opa_d   = opa_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        err_d   = err_q;
        add_s   = '0;
        mstep   = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    err_d   = 1'b0;
                    carry_d = 1'b0;
                    state_d = ST_DONE;
                    case (bus.op)
                        OP_ADD: begin
                            add_s   = {1'b0, bus.a} + {1'b0, bus.b};
                            res_d   = add_s[W-1:0];
                            carry_d = add_s[W];
                        end
                        OP_SUB: begin
                            res_d   = bus.a - bus.b;
                            carry_d = (bus.a >= bus.b);
                        end
                        OP_OR:  res_d = bus.a | bus.b;
                        OP_XOR: res_d = bus.a ^ bus.b;
                        OP_SHL: res_d = bus.a << bus.b[3:0];
                        OP_SHR: res_d = bus.a >> bus.b[3:0];
                        OP_ROTL, OP_ROTR: begin
                            res_d  = bus.a;
                            iter_d = (bus.op == OP_ROTL) ? IT_ROTL : IT_ROTR;
                            cnt_d  = CW'(rot_k);
                            if (rot_k != 5'd0) begin
                                state_d = ST_ITER;
                            end
                        end
                        OP_MUL: begin
                            // res_q doubles as the low product half, seeded with the multiplier.
                            opa_d   = bus.a;
                            res_d   = bus.b;
                            hi_d    = '0;
                            iter_d  = IT_MUL;
                            cnt_d   = CW'(MUL_ITERS);
                            state_d = ST_ITER;
                        end
                        OP_ADDC: begin
                            add_s   = {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.c_in};
                            res_d   = add_s[W-1:0];
                            carry_d = add_s[W];
                        end
                        default: begin
                            res_d = '0;
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_ITER: begin
                cnt_d = cnt_q - 1'b1;
                case (iter_q)
                    IT_ROTL: res_d = {res_q[W-2:0], res_q[W-1]};
                    IT_ROTR: res_d = {res_q[0], res_q[W-1:1]};
                    default: begin
                        mstep       = {1'b0, hi_q} + (res_q[0] ? {1'b0, opa_q} : {(W+1){1'b0}});
                        {hi_d, res_d} = {mstep, res_q[W-1:1]};
                    end
                endcase
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                    carry_d = (iter_q == IT_MUL) ? (|hi_d) : 1'b0;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Flag recomputed only on entry to DONE so it tracks the final result.
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            zero_d = (res_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            iter_q  <= IT_ROTL;
            res_q   <= '0;
            hi_q    <= '0;
            opa_q   <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            opa_q   <= opa_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.res       = res_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.err       = err_q;

`ifdef ALU_SEQ_PERF_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == ST_DONE && bus.out_ready && perf_q != 16'hFFFF) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= 16'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_ops = perf_q;
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized scoreboard bench for alu_op_sequencer
module tb_alu_op_sequencer;
    localparam int W = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.W(W)) bus ();
`ifdef ALU_SEQ_PERF_EN
    logic [15:0] perf_ops;
`endif

    alu_op_sequencer #(.W(W), .MUL_ITERS(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef ALU_SEQ_PERF_EN
        .perf_ops (perf_ops),
`endif
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        logic         carry;
        logic         err;
        int           lat;
        int           acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   perf_base = 0;
    bit   bp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin);
        exp_t e;
        longint unsigned ua, ub, r, mask;
        int k;
        ua = 64'(a);
        ub = 64'(b);
        mask = (64'd1 << W) - 64'd1;
        k = int'(b[4:0]) % W;
        r = 0;
        e.carry = 1'b0;
        e.err = 1'b0;
        e.lat = 0;
        case (op)
            4'd0: begin r = ua + ub; e.carry = r[W]; end
            4'd1: begin r = ua - ub; e.carry = (ua >= ub); end
            4'd2: r = ua | ub;
            4'd3: r = ua ^ ub;
            4'd4: r = ua << b[3:0];
            4'd5: r = ua >> b[3:0];
            4'd6: begin r = (k == 0) ? ua : ((ua << k) | (ua >> (W - k))); e.lat = k; end
            4'd7: begin r = (k == 0) ? ua : ((ua >> k) | (ua << (W - k))); e.lat = k; end
            4'd8: begin r = ua * ub; e.carry = ((r >> W) != 0); e.lat = 20; end
            4'd9: begin r = ua + ub + 64'(cin); e.carry = r[W]; end
            default: begin r = 0; e.err = 1'b1; end
        endcase
        e.res = W'(r & mask);
        e.zero = (e.res == '0);
        e.acc_cyc = 0;
        return e;
    endfunction

    // Consumer readiness: random unless a directed test is holding it low.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready = bp ? 1'b0 : ($urandom_range(3) != 0);
        end
    end

    // Monitor: latency on rise of out_valid, hold stability, result on transfer.
    initial begin
        logic prev;
        logic [W-1:0] hres;
        logic [2:0] hflags;
        exp_t e;
        prev = 1'b0;
        hres = '0;
        hflags = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0;
                continue;
            end
            if (bus.out_valid) begin
                check("in_ready_low_in_done", bus.in_ready, 1'b0);
                if (!prev) begin
                    hres = bus.res;
                    hflags = {bus.zero, bus.carry, bus.err};
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_result: got res %0h, expected no output", bus.res);
                    end else begin
                        check("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
                    end
                end else begin
                    check("hold_res", bus.res, hres);
                    check("hold_flags", {bus.zero, bus.carry, bus.err}, hflags);
                end
                if (bus.out_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    check("res", bus.res, e.res);
                    check("zero", bus.zero, e.zero);
                    check("carry", bus.carry, e.carry);
                    check("err", bus.err, e.err);
                    done_cnt++;
                end
            end
            prev = bus.out_valid;
        end
    end

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        exp_t e;
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.c_in = cin;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got in_ready 0, expected 1 within 200 cycles");
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e = model(op, a, b, cin);
        e.acc_cyc = cyc;
        sb.push_back(e);
        bus.in_valid = 1'b0;
        bus.op = 4'($urandom);
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        bus.c_in = 1'($urandom);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic random_ops(input int count);
        logic [W-1:0] ra, rb;
        for (int i = 0; i < count; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(1) == 0) ? W'($urandom) : W'($urandom_range(31));
            send(4'($urandom_range(15)), ra, rb, 1'($urandom));
        end
    endtask

    initial begin
        int n;
        bit seen;
        bus.in_valid = 1'b0;
        bus.op = 4'd0;
        bus.a = '0;
        bus.b = '0;
        bus.c_in = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_res", bus.res, '0);
        check("rst_flags", {bus.zero, bus.carry, bus.err}, 3'b000);
`ifdef ALU_SEQ_PERF_EN
        check("rst_perf_ops", perf_ops, 16'd0);
`endif
        rst_n = 1'b1;

        send(4'd0, 20'hFFFFF, 20'h00001, 1'b0);
        send(4'd1, 20'h00005, 20'h00007, 1'b0);
        send(4'd9, 20'h00001, 20'h00001, 1'b1);
        send(4'd7, 20'h00001, 20'd3, 1'b0);
        send(4'd6, 20'h80000, 20'd21, 1'b0);
        send(4'd6, 20'h12345, 20'd20, 1'b0);
        send(4'd8, 20'd3, 20'd5, 1'b0);
        send(4'd8, 20'h00400, 20'h00400, 1'b0);
        send(4'd4, 20'h0000F, 20'h00013, 1'b0);
        send(4'd5, 20'h80000, 20'h0000F, 1'b0);
        send(4'hF, 20'h12345, 20'h54321, 1'b1);
        random_ops(80);
        wait_drain();

        // Backpressure: result held while a second request waits.
        bp = 1'b1;
        send(4'd0, 20'h12345, 20'h06789, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = 4'd3;
        bus.a = 20'hAAAAA;
        bus.b = 20'h0F0F0;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", bus.in_ready, 1'b0);
            check("bp_out_valid", bus.out_valid, 1'b1);
        end
        bp = 1'b0;
        send(4'd3, 20'hAAAAA, 20'h0F0F0, 1'b0);
        wait_drain();

        // Reset abort in the middle of a multiply.
        send(4'd8, W'($urandom), W'($urandom), 1'b0);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", bus.out_valid, 1'b0);
        check("abort_in_ready", bus.in_ready, 1'b1);
        check("abort_res", bus.res, '0);
        sb.delete();
        perf_base = done_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("no_stale_result", seen, 1'b0);

        random_ops(30);
        wait_drain();
        repeat (3) @(negedge clk);
`ifdef ALU_SEQ_PERF_EN
        check("perf_ops", perf_ops, 16'(done_cnt - perf_base));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
